if_prefetch: RTL

- Parametrised successor to the pc + if_id fetch front end.
- Issues instruction fetches on a req/gnt/rvalid instruction-memory bus with variable latency and up to MAX_OS outstanding requests.
- Buffers returned instructions in a DEPTH-entry FIFO and hands them to decode over a valid/ready interface.
- Handles jump redirects from ctrl by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 20 ++
 rtl/if_prefetch_fetch_fifo.sv | 70 +++++++
 rtl/if_prefetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// if_prefetch_pkg
// Shared definitions for the instruction prefetch front end: default bus
// widths, the default reset fetch address and a ceil(log2) helper used to
// size the FIFO pointers and the occupancy / outstanding-request counters.
// ----------------------------------------------------------------------------
package if_prefetch_pkg;

  localparam int          INST_AW = 32;            // instruction address bus
  localparam int          INST_DW = 32;            // instruction data bus
  localparam logic [31:0] RST_PC  = 32'h0000_0000; // default first fetch

  // Smallest r with 2**r >= n; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// ----------------------------------------------------------------------------
// if_prefetch_fetch_fifo
// Synchronous DEPTH-entry FIFO holding {address, instruction} records.
// Flush has priority over push and pop. When the FIFO is empty, head keeps
// showing the last entry that was at the head (zero after reset).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write wdata at the tail
//   pop           drop the head entry
//   flush         empty the FIFO (push/pop that cycle ignored)
//   count         number of valid entries (0..DEPTH)
//   head          head entry, or last head value when empty
// ----------------------------------------------------------------------------
module if_prefetch_fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [W-1:0]  hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (count != '0) hold_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: it is only observed through head while count != 0.
  // On a full push+pop the write lands in the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : hold_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch
// Instruction prefetch front end. Issues word fetches on a req/gnt/rvalid
// bus with up to MAX_OS requests in flight, buffers responses in a DEPTH
// entry FIFO and presents them to decode over valid/ready. A jump flushes
// the FIFO, redirects the PC and marks every in-flight response for drop.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   jump_en_i        redirect request from ctrl
//   jump_addr_i      redirect target (bits [1:0] ignored)
//   imem_req_o       fetch request valid
//   imem_addr_o      fetch address (word aligned)
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    in-order response valid
//   imem_rdata_i     response instruction
//   inst_valid_o     FIFO head valid to decode
//   inst_o           head instruction
//   inst_addr_o      head instruction address
//   inst_ready_i     decode accepts head
// ----------------------------------------------------------------------------
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int            AW       = INST_AW,
  parameter int            DW       = INST_DW,
  parameter int            DEPTH    = 4,
  parameter int            MAX_OS   = 2,
  parameter logic [AW-1:0] RESET_PC = AW'(RST_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  input  logic          inst_ready_i
);

  localparam int CW = clog2(DEPTH + 1);

  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    resp_pc;
  logic [CW-1:0]    os_cnt;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    fifo_cnt;
  logic [CW:0]      slots_used;
  logic [AW-1:0]    jump_pc;
  logic [AW+DW-1:0] fifo_head;
  logic             issue;
  logic             rsp;
  logic             drop_now;
  logic             push;
  logic             pop;

  // Responses still to be dropped will never occupy the FIFO, so they do
  // not count against its capacity. drop_cnt <= os_cnt always holds.
  assign slots_used = {1'b0, fifo_cnt} + {1'b0, os_cnt} - {1'b0, drop_cnt};

  assign imem_req_o  = !rst && !jump_en_i && (os_cnt < CW'(MAX_OS)) &&
                       (slots_used < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_q;

  assign issue    = imem_req_o && imem_gnt_i;
  assign rsp      = imem_rvalid_i && (os_cnt != '0);
  assign drop_now = rsp && (drop_cnt != '0);
  assign push     = rsp && !drop_now;

  assign inst_valid_o = (fifo_cnt != '0) && !jump_en_i;
  assign pop          = inst_valid_o && inst_ready_i;

  assign jump_pc = jump_addr_i & ~AW'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      resp_pc  <= RESET_PC;
      os_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      os_cnt <= os_cnt + CW'(issue) - CW'(rsp);
      if (jump_en_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc_q     <= jump_pc;
        resp_pc  <= jump_pc;
        drop_cnt <= os_cnt - CW'(rsp);
      end else begin
        if (issue)    pc_q     <= pc_q + AW'(4);
        if (push)     resp_pc  <= resp_pc + AW'(4);
        if (drop_now) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  if_prefetch_fetch_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_en_i),
    .wdata ({resp_pc, imem_rdata_i}),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  assign inst_addr_o = fifo_head[AW+DW-1:DW];
  assign inst_o      = fifo_head[DW-1:0];

  a_rvalid_expected : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (os_cnt != '0));

endmodule
